// File: rtl/rv_dmem_responder.sv
// ----------------------------------------------------------------------------
// rv_dmem_responder
//
// Data-memory responder sitting at the far end of the regf2mem / mem2regf
// request/response interface. Word read/write requests go to an internal
// word-addressed RAM. Reads come back tagged with the request cid after a
// fixed latency. They are buffered so the register file can stall the
// response channel.
//
// Ports
//   sclk                clock, all logic on posedge
//   rst                 synchronous active-high reset
//   regf2mem_req_valid  request valid
//   mem2regf_req_ready  request ready (registered credit state only)
//   regf2mem_req_type   2'b01 write, 2'b10 read, others illegal
//   regf2mem_req_addr   byte address (word index = addr[AW+1:2])
//   regf2mem_req_data   write data
//   regf2mem_req_len    must be 4'h0 (4 bytes), anything else is illegal
//   regf2mem_req_mask   byte enables for writes
//   regf2mem_req_cid    request tag, echoed on the read response
//   mem2regf_rsp_vld    response valid
//   regf2mem_rsp_ready  response ready
//   mem2regf_rsp_cid    response tag
//   mem2regf_rsp_data   read data
//   mem2regf_err        one-cycle pulse after an illegal request is accepted
// ----------------------------------------------------------------------------
module rv_dmem_responder #(
    parameter int DEPTH     = 1024,
    parameter int RD_LAT    = 2,
    parameter int RSP_DEPTH = 4
) (
    input  logic        sclk,
    input  logic        rst,
    input  logic        regf2mem_req_valid,
    output logic        mem2regf_req_ready,
    input  logic [1:0]  regf2mem_req_type,
    input  logic [31:0] regf2mem_req_addr,
    input  logic [31:0] regf2mem_req_data,
    input  logic [3:0]  regf2mem_req_len,
    input  logic [3:0]  regf2mem_req_mask,
    input  logic [4:0]  regf2mem_req_cid,
    output logic        mem2regf_rsp_vld,
    input  logic        regf2mem_rsp_ready,
    output logic [4:0]  mem2regf_rsp_cid,
    output logic [31:0] mem2regf_rsp_data,
    output logic        mem2regf_err
);

    localparam int AW     = $clog2(DEPTH);
    // A one-entry FIFO still gets a one-bit index so the pointer slicing
    // below stays legal.
    localparam int FAW    = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW     = $clog2(RSP_DEPTH + 1);
    localparam int STAGES = RD_LAT - 1;

    localparam logic [1:0] TYPE_WR = 2'b01;
    localparam logic [1:0] TYPE_RD = 2'b10;

    typedef struct packed {
        logic        wr;
        logic        rd;
        logic        bad;
        logic [AW-1:0] widx;
    } req_t;

    typedef struct packed {
        logic [4:0]  cid;
        logic [31:0] data;
    } rsp_t;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic          req_acc;
    logic          req_legal;
    req_t          req;
    logic          unused_addr;

    logic [CW-1:0] outstanding;

    // Ready depends only on the registered credit count. The response-side
    // ready never reaches the request side combinationally.
    assign mem2regf_req_ready = (outstanding != CW'(RSP_DEPTH));
    assign req_acc            = regf2mem_req_valid && mem2regf_req_ready;

    assign req_legal = (regf2mem_req_len == 4'h0) &&
                       ((regf2mem_req_type == TYPE_WR) || (regf2mem_req_type == TYPE_RD));

    assign req.wr   = req_acc && req_legal && (regf2mem_req_type == TYPE_WR);
    assign req.rd   = req_acc && req_legal && (regf2mem_req_type == TYPE_RD);
    assign req.bad  = req_acc && !req_legal;
    // Upper address bits wrap and the byte offset is ignored.
    assign req.widx = regf2mem_req_addr[AW+1:2];

    assign unused_addr = ^{regf2mem_req_addr[31:AW+2], regf2mem_req_addr[1:0]};

    // ------------------------------------------------------------------
    // Word RAM with byte enables (not reset)
    // ------------------------------------------------------------------
    logic [31:0] ram [DEPTH];
    rsp_t        rd_rsp;

    always_ff @(posedge sclk) begin
        if (req.wr) begin
            for (int b = 0; b < 4; b++) begin
                if (regf2mem_req_mask[b])
                    ram[req.widx][8*b +: 8] <= regf2mem_req_data[8*b +: 8];
            end
        end
    end

    // The read sees the array before this edge's write. Only one request is
    // accepted per cycle, so a read never collides with a write.
    assign rd_rsp = {regf2mem_req_cid, ram[req.widx]};

    // ------------------------------------------------------------------
    // Read delay line: RD_LAT-1 registered stages. The RAM is read into the
    // first stage. With RD_LAT == 1 the read goes straight to the response
    // buffer.
    // ------------------------------------------------------------------
    logic push_vld;
    rsp_t push_rsp;

    generate
        if (STAGES == 0) begin : g_no_pipe
            assign push_vld = req.rd;
            assign push_rsp = rd_rsp;
        end else begin : g_pipe
            logic [STAGES:1] vld_pipe;
            rsp_t            dat_pipe [STAGES:1];

            always_ff @(posedge sclk) begin
                if (rst) begin
                    vld_pipe <= '0;
                end else begin
                    vld_pipe[1] <= req.rd;
                    for (int s = 2; s <= STAGES; s++)
                        vld_pipe[s] <= vld_pipe[s-1];
                end
            end

            // Payload needs no reset: it is only consumed when its valid is set.
            always_ff @(posedge sclk) begin
                dat_pipe[1] <= rd_rsp;
                for (int s = 2; s <= STAGES; s++)
                    dat_pipe[s] <= dat_pipe[s-1];
            end

            assign push_vld = vld_pipe[STAGES];
            assign push_rsp = dat_pipe[STAGES];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Response buffer: FIFO feeding a registered output slot.
    // When the FIFO is empty and the slot can load, a fresh read bypasses
    // the FIFO, so the minimum latency stays RD_LAT. Older entries in the
    // FIFO always win, so responses leave in accept order. The credit
    // counter bounds slot + FIFO + delay line to RSP_DEPTH, so the FIFO
    // cannot overflow.
    // ------------------------------------------------------------------
    rsp_t         fifo [1<<FAW];
    logic [FAW:0] wr_ptr;
    logic [FAW:0] rd_ptr;
    logic         fifo_empty;
    logic         fifo_push;
    logic         out_load;
    logic         rsp_xfer;
    logic         out_vld;
    rsp_t         out_q;
    logic         err_q;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign rsp_xfer   = out_vld && regf2mem_rsp_ready;
    assign out_load   = !out_vld || regf2mem_rsp_ready;
    assign fifo_push  = push_vld && !(out_load && fifo_empty);

    always_ff @(posedge sclk) begin
        if (fifo_push)
            fifo[wr_ptr[FAW-1:0]] <= push_rsp;
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            out_vld     <= 1'b0;
            out_q       <= '0;
            outstanding <= '0;
            err_q       <= 1'b0;
        end else begin
            err_q <= req.bad;

            if (fifo_push)
                wr_ptr <= wr_ptr + 1'b1;

            // The slot keeps its last payload when nothing new arrives.
            if (out_load) begin
                if (!fifo_empty) begin
                    out_q   <= fifo[rd_ptr[FAW-1:0]];
                    out_vld <= 1'b1;
                    rd_ptr  <= rd_ptr + 1'b1;
                end else if (push_vld) begin
                    out_q   <= push_rsp;
                    out_vld <= 1'b1;
                end else begin
                    out_vld <= 1'b0;
                end
            end

            case ({req.rd, rsp_xfer})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    assign mem2regf_rsp_vld  = out_vld;
    assign mem2regf_rsp_cid  = out_q.cid;
    assign mem2regf_rsp_data = out_q.data;
    assign mem2regf_err      = err_q;

endmodule

// File: tb/tb_rv_dmem_responder.sv
// ----------------------------------------------------------------------------
// tb_rv_dmem_responder
//
// Self-checking bench for rv_dmem_responder. A vector table drives the
// bench's requests one by one. Each accepted legal read pushes its expected
// {cid, data} onto a scoreboard queue. A negedge monitor pops and compares
// every response transfer. Hand-written sequences cover these cases:
//   - read latency
//   - backpressure / credit limit
//   - back-to-back streaming
//   - reset in the middle of traffic
// ----------------------------------------------------------------------------
module tb_rv_dmem_responder;

    localparam int DEPTH     = 1024;
    localparam int RD_LAT    = 2;
    localparam int RSP_DEPTH = 4;

    localparam logic [1:0] T_WR = 2'b01;
    localparam logic [1:0] T_RD = 2'b10;

    logic        sclk;
    logic        rst;
    logic        regf2mem_req_valid;
    logic        mem2regf_req_ready;
    logic [1:0]  regf2mem_req_type;
    logic [31:0] regf2mem_req_addr;
    logic [31:0] regf2mem_req_data;
    logic [3:0]  regf2mem_req_len;
    logic [3:0]  regf2mem_req_mask;
    logic [4:0]  regf2mem_req_cid;
    logic        mem2regf_rsp_vld;
    logic        regf2mem_rsp_ready;
    logic [4:0]  mem2regf_rsp_cid;
    logic [31:0] mem2regf_rsp_data;
    logic        mem2regf_err;

    rv_dmem_responder #(
        .DEPTH     (DEPTH),
        .RD_LAT    (RD_LAT),
        .RSP_DEPTH (RSP_DEPTH)
    ) dut (
        .sclk               (sclk),
        .rst                (rst),
        .regf2mem_req_valid (regf2mem_req_valid),
        .mem2regf_req_ready (mem2regf_req_ready),
        .regf2mem_req_type  (regf2mem_req_type),
        .regf2mem_req_addr  (regf2mem_req_addr),
        .regf2mem_req_data  (regf2mem_req_data),
        .regf2mem_req_len   (regf2mem_req_len),
        .regf2mem_req_mask  (regf2mem_req_mask),
        .regf2mem_req_cid   (regf2mem_req_cid),
        .mem2regf_rsp_vld   (mem2regf_rsp_vld),
        .regf2mem_rsp_ready (regf2mem_rsp_ready),
        .mem2regf_rsp_cid   (mem2regf_rsp_cid),
        .mem2regf_rsp_data  (mem2regf_rsp_data),
        .mem2regf_err       (mem2regf_err)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    typedef struct packed {
        logic [4:0]  cid;
        logic [31:0] data;
    } rsp_t;

    typedef struct {
        string       name;
        logic [1:0]  typ;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
        logic [3:0]  len;
        logic [4:0]  cid;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    rsp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   rsp_count = 0;
    int   cyc = 0;
    bit   gap_track = 1'b0;
    bit   have_prev = 1'b0;
    int   prev_cyc = 0;
    int   gaps = 0;

    always @(posedge sclk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Response monitor: a transfer is visible at the negedge before its edge.
    always @(negedge sclk) begin
        if (!rst && mem2regf_rsp_vld && regf2mem_rsp_ready) begin
            rsp_t e;
            rsp_count++;
            if (gap_track) begin
                if (have_prev && cyc != prev_cyc + 1) gaps++;
                prev_cyc  = cyc;
                have_prev = 1'b1;
            end
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got cid %0d data %0h, required no response",
                         mem2regf_rsp_cid, mem2regf_rsp_data);
            end else begin
                e = sb.pop_front();
                check("rsp_cid", 64'(mem2regf_rsp_cid), 64'(e.cid));
                check("rsp_data", 64'(mem2regf_rsp_data), 64'(e.data));
            end
        end
    end

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic idle();
        regf2mem_req_valid = 1'b0;
        regf2mem_req_type  = 2'b00;
    endtask

    function automatic vec_t mk(input string n, input logic [1:0] t, input logic [31:0] a,
                                input logic [31:0] d, input logic [3:0] m, input logic [3:0] l,
                                input logic [4:0] c, input logic [31:0] ed, input logic ee);
        vec_t v;
        v.name = n; v.typ = t; v.addr = a; v.data = d; v.mask = m; v.len = l;
        v.cid = c; v.exp_data = ed; v.exp_err = ee;
        return v;
    endfunction

    // Drive one request, hold it until accepted, then check the err pulse
    // right after the accepting edge. Returns at posedge+1 with valid still
    // high, so consecutive calls are back-to-back.
    task automatic send(input vec_t v, output int waits);
        regf2mem_req_valid = 1'b1;
        regf2mem_req_type  = v.typ;
        regf2mem_req_addr  = v.addr;
        regf2mem_req_data  = v.data;
        regf2mem_req_mask  = v.mask;
        regf2mem_req_len   = v.len;
        regf2mem_req_cid   = v.cid;
        waits = 0;
        @(negedge sclk);
        while (!mem2regf_req_ready && waits < 100) begin
            waits++;
            @(negedge sclk);
        end
        if (!mem2regf_req_ready) begin
            checks++;
            errors++;
            $display("FAIL %s accept_timeout: req_ready 0, required 1 within 100 cycles", v.name);
            idle();
            tick();
            return;
        end
        if (v.typ == T_RD && v.len == 4'h0)
            sb.push_back({v.cid, v.exp_data});
        tick();
        check({v.name, "_err"}, 64'(mem2regf_err), 64'(v.exp_err));
    endtask

    task automatic wait_drain(input string name, output int n);
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s drain_timeout: %0d responses outstanding, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        vec_t vt [16];
        int   w;
        int   n;
        int   accepted;
        int   rc0;
        int   wsum;
        int   vld_seen;

        // 0x1000 = DEPTH*4, so 0x1010 aliases 0x10 and 0x3FFC aliases 0xFFC.
        vt[0]  = mk("wr_20_ones",  T_WR,  32'h20,   32'hFFFF_FFFF, 4'hF, 4'h0, 5'd0,  32'h0,         1'b0);
        vt[1]  = mk("wr_20_byte0", T_WR,  32'h20,   32'h0000_0012, 4'h1, 4'h0, 5'd0,  32'h0,         1'b0);
        vt[2]  = mk("rd_20",       T_RD,  32'h20,   32'h0,         4'h0, 4'h0, 5'd6,  32'hFFFF_FF12, 1'b0);
        vt[3]  = mk("wr_24_full",  T_WR,  32'h24,   32'h1122_3344, 4'hF, 4'h0, 5'd0,  32'h0,         1'b0);
        vt[4]  = mk("wr_24_mask0", T_WR,  32'h24,   32'hAABB_CCDD, 4'h0, 4'h0, 5'd0,  32'h0,         1'b0);
        vt[5]  = mk("rd_24_a",     T_RD,  32'h24,   32'h0,         4'h0, 4'h0, 5'd7,  32'h1122_3344, 1'b0);
        vt[6]  = mk("wr_24_mskA",  T_WR,  32'h24,   32'hAABB_CCDD, 4'hA, 4'h0, 5'd0,  32'h0,         1'b0);
        vt[7]  = mk("rd_27_mis",   T_RD,  32'h27,   32'h0,         4'h0, 4'h0, 5'd8,  32'hAA22_CC44, 1'b0);
        vt[8]  = mk("rd_1010",     T_RD,  32'h1010, 32'h0,         4'h0, 4'h0, 5'd9,  32'hDEAD_BEEF, 1'b0);
        vt[9]  = mk("bad_type11",  2'b11, 32'h10,   32'h0,         4'hF, 4'h0, 5'd20, 32'h0,         1'b1);
        vt[10] = mk("wr_ffc",      T_WR,  32'hFFC,  32'h0BAD_F00D, 4'hF, 4'h0, 5'd0,  32'h0,         1'b0);
        vt[11] = mk("bad_len_wr",  T_WR,  32'h10,   32'h0,         4'hF, 4'h1, 5'd0,  32'h0,         1'b1);
        vt[12] = mk("bad_len_rd",  T_RD,  32'h10,   32'h0,         4'h0, 4'h2, 5'd21, 32'h0,         1'b1);
        vt[13] = mk("bad_type00",  2'b00, 32'h24,   32'h0,         4'hF, 4'h0, 5'd22, 32'h0,         1'b1);
        vt[14] = mk("rd_10_keep",  T_RD,  32'h10,   32'h0,         4'h0, 4'h0, 5'd10, 32'hDEAD_BEEF, 1'b0);
        vt[15] = mk("rd_3ffc",     T_RD,  32'h3FFC, 32'h0,         4'h0, 4'h0, 5'd11, 32'h0BAD_F00D, 1'b0);

        // Reset
        rst = 1'b1;
        regf2mem_rsp_ready = 1'b1;
        regf2mem_req_addr  = '0;
        regf2mem_req_data  = '0;
        regf2mem_req_mask  = '0;
        regf2mem_req_len   = '0;
        regf2mem_req_cid   = '0;
        idle();
        repeat (3) tick();
        rst = 1'b0;
        check("reset_rsp_vld", 64'(mem2regf_rsp_vld), 64'(0));
        check("reset_rsp_cid", 64'(mem2regf_rsp_cid), 64'(0));
        check("reset_rsp_data", 64'(mem2regf_rsp_data), 64'(0));
        check("reset_err", 64'(mem2regf_err), 64'(0));
        check("reset_req_ready", 64'(mem2regf_req_ready), 64'(1));

        // Write then read on the next cycle, and measure latency.
        send(mk("wr_10", T_WR, 32'h10, 32'hDEAD_BEEF, 4'hF, 4'h0, 5'd0, 32'h0, 1'b0), w);
        send(mk("rd_10", T_RD, 32'h10, 32'h0, 4'h0, 4'h0, 5'd5, 32'hDEAD_BEEF, 1'b0), w);
        idle();
        n = 0;
        while (!mem2regf_rsp_vld && n < 10) begin
            tick();
            n++;
        end
        // Edges after the accepting edge until rsp_vld shows up.
        check("rd_latency_edges", 64'(n), 64'(RD_LAT - 1));
        wait_drain("first_read", n);

        // Table of writes, reads and illegal requests, back to back.
        for (int i = 0; i < 16; i++) send(vt[i], w);
        idle();
        wait_drain("table", n);
        tick();
        check("err_clears", 64'(mem2regf_err), 64'(0));

        // Backpressure: 6 reads with rsp_ready low, only RSP_DEPTH accepted.
        regf2mem_rsp_ready = 1'b0;
        regf2mem_req_type  = T_RD;
        regf2mem_req_addr  = 32'h10;
        regf2mem_req_len   = 4'h0;
        accepted = 0;
        for (int c = 0; c < 8; c++) begin
            regf2mem_req_valid = 1'b1;
            regf2mem_req_cid   = 5'(accepted + 1);
            @(negedge sclk);
            if (mem2regf_req_ready) begin
                sb.push_back({5'(accepted + 1), 32'hDEAD_BEEF});
                accepted++;
            end
            tick();
        end
        check("stall_accepted", 64'(accepted), 64'(RSP_DEPTH));
        check("stall_ready_low", 64'(mem2regf_req_ready), 64'(0));
        check("stall_rsp_vld", 64'(mem2regf_rsp_vld), 64'(1));
        check("stall_rsp_cid_held", 64'(mem2regf_rsp_cid), 64'(1));
        regf2mem_rsp_ready = 1'b1;
        n = 0;
        while (accepted < 6 && n < 30) begin
            regf2mem_req_valid = 1'b1;
            regf2mem_req_cid   = 5'(accepted + 1);
            @(negedge sclk);
            if (mem2regf_req_ready) begin
                sb.push_back({5'(accepted + 1), 32'hDEAD_BEEF});
                accepted++;
            end
            tick();
            n++;
        end
        idle();
        check("stall_all_accepted", 64'(accepted), 64'(6));
        wait_drain("stall", n);

        // Streaming reads: no stalls, one response per cycle.
        rc0 = rsp_count;
        wsum = 0;
        gaps = 0;
        have_prev = 1'b0;
        gap_track = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(mk("stream_rd", T_RD, 32'h20, 32'h0, 4'h0, 4'h0, 5'(12 + i), 32'hFFFF_FF12, 1'b0), w);
            wsum += w;
        end
        idle();
        wait_drain("stream", n);
        gap_track = 1'b0;
        check("stream_ready_waits", 64'(wsum), 64'(0));
        check("stream_drain_edges", 64'(n), 64'(RD_LAT));
        check("stream_rsp_count", 64'(rsp_count - rc0), 64'(8));
        check("stream_gaps", 64'(gaps), 64'(0));

        // Reset with reads in flight: they vanish, RAM contents survive.
        regf2mem_rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send(mk("pre_rst_rd", T_RD, 32'h10, 32'h0, 4'h0, 4'h0, 5'(25 + i), 32'hDEAD_BEEF, 1'b0), w);
        idle();
        rst = 1'b1;
        sb.delete();
        tick();
        rst = 1'b0;
        regf2mem_rsp_ready = 1'b1;
        check("rst2_rsp_vld", 64'(mem2regf_rsp_vld), 64'(0));
        check("rst2_rsp_cid", 64'(mem2regf_rsp_cid), 64'(0));
        check("rst2_rsp_data", 64'(mem2regf_rsp_data), 64'(0));
        check("rst2_req_ready", 64'(mem2regf_req_ready), 64'(1));
        vld_seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge sclk);
            if (mem2regf_rsp_vld) vld_seen++;
        end
        tick();
        check("rst2_no_rsp", 64'(vld_seen), 64'(0));
        send(mk("post_rst_rd20", T_RD, 32'h20, 32'h0, 4'h0, 4'h0, 5'd3, 32'hFFFF_FF12, 1'b0), w);
        send(mk("post_rst_rd1010", T_RD, 32'h1010, 32'h0, 4'h0, 4'h0, 5'd4, 32'hDEAD_BEEF, 1'b0), w);
        idle();
        wait_drain("post_reset", n);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
